// File: rtl/hatch_ctrl.sv
// Egg-hatching stage sequencer with debounced setpoint keys; drives the LED display stage.
// Latency: run -> st/IDLE in 3 edges; key rise -> tmp_val in 2+DEB_TICKS+1 edges; temp one edge later.
// Backpressure: none; outputs free-run, stage advance stalls while the setpoint is out of band.

module hatch_ctrl_deb #(
  parameter int DEB_TICKS = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_press
);
  localparam int CW = $clog2(DEB_TICKS + 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_acc;
  logic          r_acc_q;
  logic [CW-1:0] r_cnt;

  // Two-flop synchroniser for the raw, asynchronous key level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
    end
  end

  // Accept a new level only after DEB_TICKS consecutive samples disagreeing with the old one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_acc   <= 1'b0;
      r_acc_q <= 1'b0;
    end else begin
      r_acc_q <= r_acc;
      if (r_s2 == r_acc) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEB_TICKS - 1)) begin
        r_acc <= r_s2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // One-cycle pulse on the rising edge of the accepted level
  assign o_press = r_acc & ~r_acc_q;
endmodule

module hatch_ctrl #(
  parameter int TICKS_PER_SEC = 1000,
  parameter int STAGE_SEC     = 2,
  parameter int DEB_TICKS     = 20,
  parameter int TEMP_INIT     = 37,
  parameter int TEMP_LO       = 36,
  parameter int TEMP_HI       = 38,
  parameter int TEMP_MIN      = 30,
  parameter int TEMP_MAX      = 45
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       key_up,
  input  logic       key_dn,
  output logic [3:0] num,
  output logic       temp,
  output logic       st,
  output logic [5:0] tmp_val,
  output logic       done
);
  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int SW = (STAGE_SEC > 1) ? $clog2(STAGE_SEC) : 1;
  localparam logic [3:0] NUM_LAST = 4'd11;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  state_t        r_state;
  logic          r_run_s1;
  logic          r_run_s2;
  logic [3:0]    r_num;
  logic          r_st;
  logic          r_done;
  logic          r_temp;
  logic [5:0]    r_tmp;
  logic [PW-1:0] r_presc;
  logic [SW-1:0] r_sec;

  logic w_up_press;
  logic w_dn_press;
  logic w_cnt_en;
  logic w_presc_max;
  logic w_sec_max;
  logic w_step;

  hatch_ctrl_deb #(.DEB_TICKS(DEB_TICKS)) u_deb_up (
    .clk     (clk),
    .rst     (rst),
    .i_raw   (key_up),
    .o_press (w_up_press)
  );

  hatch_ctrl_deb #(.DEB_TICKS(DEB_TICKS)) u_deb_dn (
    .clk     (clk),
    .rst     (rst),
    .i_raw   (key_dn),
    .o_press (w_dn_press)
  );

  // Two-flop synchroniser for the operator run switch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run_s1 <= 1'b0;
      r_run_s2 <= 1'b0;
    end else begin
      r_run_s1 <= run;
      r_run_s2 <= r_run_s1;
    end
  end

  // Setpoint: saturating +/-1 per press; simultaneous presses cancel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmp <= 6'(TEMP_INIT);
    end else if (w_up_press && !w_dn_press && (r_tmp < 6'(TEMP_MAX))) begin
      r_tmp <= r_tmp + 6'd1;
    end else if (w_dn_press && !w_up_press && (r_tmp > 6'(TEMP_MIN))) begin
      r_tmp <= r_tmp - 6'd1;
    end
  end

  // Out-of-band flag, registered from the current setpoint
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_temp <= 1'b0;
    end else begin
      r_temp <= (r_tmp < 6'(TEMP_LO)) || (r_tmp > 6'(TEMP_HI));
    end
  end

  // Count on every edge whose next state is RUN with the band OK. Counting on the
  // PAUSE->RUN edge makes a fault delay the next step by exactly its temp-high cycles.
  assign w_cnt_en    = !r_temp && (r_num != NUM_LAST) &&
                       ((r_state == S_RUN) || (r_state == S_PAUSE));
  assign w_presc_max = (r_presc == PW'(TICKS_PER_SEC - 1));
  assign w_sec_max   = (r_sec == SW'(STAGE_SEC - 1));
  assign w_step      = w_cnt_en && w_presc_max && w_sec_max;

  // Prescaler and seconds counter: frozen outside counting, cleared while run is low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
      r_sec   <= '0;
    end else if (!r_run_s2) begin
      r_presc <= '0;
      r_sec   <= '0;
    end else if (w_cnt_en) begin
      if (w_presc_max) begin
        r_presc <= '0;
        r_sec   <= w_sec_max ? '0 : r_sec + 1'b1;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
    end
  end

  // Sequencer FSM with registered stage/enable/done outputs; run low wins over everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_num   <= 4'd0;
      r_st    <= 1'b0;
      r_done  <= 1'b0;
    end else if (!r_run_s2) begin
      r_state <= S_IDLE;
      r_num   <= 4'd0;
      r_st    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_RUN;
          r_st    <= 1'b1;
        end
        S_RUN: begin
          if (r_num == NUM_LAST) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else if (r_temp) begin
            r_state <= S_PAUSE;
          end else if (w_step) begin
            r_num <= r_num + 4'd1;
          end
        end
        S_PAUSE: begin
          if (!r_temp) begin
            r_state <= S_RUN;
            if (w_step) begin
              r_num <= r_num + 4'd1;
            end
          end
        end
        S_DONE: begin
          r_done <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign num     = r_num;
  assign st      = r_st;
  assign done    = r_done;
  assign temp    = r_temp;
  assign tmp_val = r_tmp;
endmodule

// File: tb/tb_hatch_ctrl.sv
// Bench for hatch_ctrl with a fast schedule (4 ticks/s, 2 s/stage, 3-cycle debounce).
// Latency: all expectations are cycle offsets from the cycle a stimulus was applied.
// Backpressure: not applicable; inputs are driven #1 after the rising edge, outputs sampled there too.

module tb_hatch_ctrl;
  logic       clk;
  logic       rst;
  logic       run;
  logic       key_up;
  logic       key_dn;
  logic [3:0] num;
  logic       temp;
  logic       st;
  logic [5:0] tmp_val;
  logic       done;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    int         cyc;
    logic [3:0] num;
  } ev_t;

  ev_t sb_q[$];

  hatch_ctrl #(
    .TICKS_PER_SEC (4),
    .STAGE_SEC     (2),
    .DEB_TICKS     (3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .key_up  (key_up),
    .key_dn  (key_dn),
    .num     (num),
    .temp    (temp),
    .st      (st),
    .tmp_val (tmp_val),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic tick_until(input int t);
    while (cyc < t) tick();
  endtask

  task automatic do_reset();
    run    = 1'b0;
    key_up = 1'b0;
    key_dn = 1'b0;
    rst    = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Clean press: 5 cycles high then 5 low; tmp_val moves 6 cycles after the start
  task automatic press(input logic up, input logic dn);
    key_up = up;
    key_dn = dn;
    repeat (5) tick();
    key_up = 1'b0;
    key_dn = 1'b0;
    repeat (5) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b0; key_up = 1'b0; key_dn = 1'b0;
    tick();
    n_tests++; if (num !== 4'd0) begin n_fail++; $display("FAIL reset_num: got %0d want 0", num); end
    n_tests++; if (st !== 1'b0) begin n_fail++; $display("FAIL reset_st: got %b want 0", st); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_tests++; if (tmp_val !== 6'd37) begin n_fail++; $display("FAIL reset_tmp: got %0d want 37", tmp_val); end
    n_tests++; if (temp !== 1'b0) begin n_fail++; $display("FAIL reset_temp: got %b want 0", temp); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_schedule();
    int c0;
    logic [3:0] prev;
    ev_t e;
    do_reset();
    c0 = cyc;
    for (int k = 1; k <= 11; k++) begin
      e.cyc = c0 + 3 + 8 * k;
      e.num = 4'(k);
      sb_q.push_back(e);
    end
    run  = 1'b1;
    prev = num;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (i == 2) begin
        n_tests++; if (st !== 1'b0) begin n_fail++; $display("FAIL sched_st_early: got %b want 0", st); end
      end
      if (i == 3) begin
        n_tests++; if (st !== 1'b1) begin n_fail++; $display("FAIL sched_st_on: got %b want 1", st); end
      end
      if (i == 91) begin
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL sched_done_early: got %b want 0", done); end
      end
      if (i == 92) begin
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL sched_done_rise: got %b want 1", done); end
      end
      if (num !== prev) begin
        n_tests++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL sched_extra_step: num %0d at cycle %0d, no further step expected", num, cyc - c0);
        end else begin
          e = sb_q.pop_front();
          if (num !== e.num || cyc !== e.cyc) begin
            n_fail++;
            $display("FAIL sched_step: got num %0d at cycle %0d, want num %0d at cycle %0d",
                     num, cyc - c0, e.num, e.cyc - c0);
          end
        end
        prev = num;
      end
    end
    n_tests++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL sched_missing: %0d steps not seen, want 0", sb_q.size()); end
    n_tests++; if (num !== 4'd11 || done !== 1'b1) begin n_fail++; $display("FAIL sched_terminal: got num %0d done %b want 11/1", num, done); end
    sb_q.delete();
    run = 1'b0;
  endtask

  task automatic test_temp_fault();
    int c0;
    do_reset();
    c0  = cyc;
    run = 1'b1;
    tick_until(c0 + 13);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    n_tests++; if (tmp_val !== 6'd39) begin n_fail++; $display("FAIL fault_tmp_up: got %0d want 39", tmp_val); end
    n_tests++; if (temp !== 1'b1) begin n_fail++; $display("FAIL fault_temp_on: got %b want 1", temp); end
    tick_until(c0 + 50);
    n_tests++; if (num !== 4'd3) begin n_fail++; $display("FAIL fault_num_frozen: got %0d want 3", num); end
    n_tests++; if (st !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL fault_st_done: got st %b done %b want 1/0", st, done); end
    key_dn = 1'b1;
    tick_until(c0 + 55);
    key_dn = 1'b0;
    tick_until(c0 + 56);
    n_tests++; if (tmp_val !== 6'd38) begin n_fail++; $display("FAIL fault_tmp_dn: got %0d want 38", tmp_val); end
    tick_until(c0 + 57);
    n_tests++; if (temp !== 1'b0) begin n_fail++; $display("FAIL fault_temp_off: got %b want 0", temp); end
    // 3 counts were made in stage 3 before the freeze; 5 remain from the resume edge c0+58
    tick_until(c0 + 61);
    n_tests++; if (num !== 4'd3) begin n_fail++; $display("FAIL fault_resume_early: got %0d want 3", num); end
    tick_until(c0 + 62);
    n_tests++; if (num !== 4'd4) begin n_fail++; $display("FAIL fault_resume_step: got %0d want 4", num); end
    tick_until(c0 + 69);
    n_tests++; if (num !== 4'd4) begin n_fail++; $display("FAIL fault_next_early: got %0d want 4", num); end
    tick_until(c0 + 70);
    n_tests++; if (num !== 4'd5) begin n_fail++; $display("FAIL fault_next_step: got %0d want 5", num); end
    run = 1'b0;
  endtask

  task automatic test_saturation();
    int exp_t;
    do_reset();
    press(1'b1, 1'b1);
    n_tests++; if (tmp_val !== 6'd37) begin n_fail++; $display("FAIL sat_conflict: got %0d want 37", tmp_val); end
    exp_t = 37;
    for (int i = 0; i < 10; i++) begin
      press(1'b0, 1'b1);
      exp_t = (exp_t > 30) ? exp_t - 1 : 30;
      n_tests++;
      if (tmp_val !== 6'(exp_t)) begin
        n_fail++;
        $display("FAIL sat_dn_%0d: got %0d want %0d", i, tmp_val, exp_t);
      end
    end
    n_tests++; if (temp !== 1'b1) begin n_fail++; $display("FAIL sat_temp_low: got %b want 1", temp); end
  endtask

  task automatic test_debounce();
    logic [31:0] pat;
    int t0;
    do_reset();
    for (int r = 0; r < 3; r++) begin
      key_up = 1'b1;
      repeat (2) tick();
      key_up = 1'b0;
      repeat (5) tick();
    end
    pat = 32'b0110_1101_1010_0110_1100_1011_0101_1011;
    for (int i = 0; i < 32; i++) begin
      key_up = pat[i];
      tick();
    end
    key_up = 1'b0;
    repeat (10) tick();
    n_tests++; if (tmp_val !== 6'd37) begin n_fail++; $display("FAIL deb_glitch: got %0d want 37", tmp_val); end
    t0     = cyc;
    key_up = 1'b1;
    tick_until(t0 + 5);
    n_tests++; if (tmp_val !== 6'd37) begin n_fail++; $display("FAIL deb_latency_early: got %0d want 37", tmp_val); end
    tick_until(t0 + 6);
    n_tests++; if (tmp_val !== 6'd38) begin n_fail++; $display("FAIL deb_latency: got %0d want 38", tmp_val); end
    tick_until(t0 + 10);
    key_up = 1'b0;
    repeat (10) tick();
    n_tests++; if (tmp_val !== 6'd38) begin n_fail++; $display("FAIL deb_single_step: got %0d want 38", tmp_val); end
  endtask

  task automatic test_run_drop();
    int c0;
    int d;
    do_reset();
    c0  = cyc;
    run = 1'b1;
    tick_until(c0 + 5);
    press(1'b1, 1'b0);
    tick_until(c0 + 43);
    n_tests++; if (num !== 4'd5) begin n_fail++; $display("FAIL drop_num5: got %0d want 5", num); end
    tick_until(c0 + 45);
    d   = cyc;
    run = 1'b0;
    tick_until(d + 2);
    n_tests++; if (num !== 4'd5 || st !== 1'b1) begin n_fail++; $display("FAIL drop_early: got num %0d st %b want 5/1", num, st); end
    tick_until(d + 3);
    n_tests++; if (num !== 4'd0 || st !== 1'b0) begin n_fail++; $display("FAIL drop_idle: got num %0d st %b want 0/0", num, st); end
    n_tests++; if (tmp_val !== 6'd38) begin n_fail++; $display("FAIL drop_tmp_kept: got %0d want 38", tmp_val); end
    tick_until(d + 10);
    run = 1'b1;
    tick_until(d + 13);
    n_tests++; if (st !== 1'b1) begin n_fail++; $display("FAIL rerun_st: got %b want 1", st); end
    tick_until(d + 20);
    n_tests++; if (num !== 4'd0) begin n_fail++; $display("FAIL rerun_early: got %0d want 0", num); end
    tick_until(d + 21);
    n_tests++; if (num !== 4'd1) begin n_fail++; $display("FAIL rerun_step: got %0d want 1", num); end
    run = 1'b0;
  endtask

  task automatic test_async_reset();
    int c0;
    do_reset();
    c0  = cyc;
    run = 1'b1;
    tick_until(c0 + 12);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    n_tests++; if (tmp_val !== 6'd40 || temp !== 1'b1) begin n_fail++; $display("FAIL arst_pre: got tmp %0d temp %b want 40/1", tmp_val, temp); end
    n_tests++; if (num !== 4'd3 || st !== 1'b1) begin n_fail++; $display("FAIL arst_pre_num: got num %0d st %b want 3/1", num, st); end
    #2;
    rst = 1'b1;
    #1;
    n_tests++; if (num !== 4'd0) begin n_fail++; $display("FAIL arst_num: got %0d want 0", num); end
    n_tests++; if (st !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL arst_st_done: got %b/%b want 0/0", st, done); end
    n_tests++; if (tmp_val !== 6'd37) begin n_fail++; $display("FAIL arst_tmp: got %0d want 37", tmp_val); end
    n_tests++; if (temp !== 1'b0) begin n_fail++; $display("FAIL arst_temp: got %b want 0", temp); end
    run = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst    = 1'b1;
    run    = 1'b0;
    key_up = 1'b0;
    key_dn = 1'b0;
    test_reset();
    test_schedule();
    test_temp_fault();
    test_saturation();
    test_debounce();
    test_run_drop();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
